// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: loads a program word-serially, then fetches for the CPU until the halt opcode.
// Zero-latency combinational outputs from state/pc/load_ptr; loader backpressured (load_ready=0) outside LOAD.
module imem_fetch_ctrl #(
    parameter int                 ADDR_W     = 16,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
    parameter logic [DATA_W-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              restart,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] load_ptr, load_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            pc       <= RESET_PC;
            load_ptr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            load_ptr <= load_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        load_ptr_nxt = load_ptr;
        load_ready   = 1'b0;
        imem_addr    = pc;
        imem_we      = 1'b0;
        imem_wdata   = '0;
        instr        = '0;
        instr_valid  = 1'b0;
        halted       = 1'b0;

        case (state)
            LOAD: begin
                load_ready = 1'b1;
                imem_addr  = load_ptr;
                imem_we    = load_valid;
                imem_wdata = load_data;
                if (load_valid) begin
                    // pointer wraps naturally at the top of the address space
                    load_ptr_nxt = load_ptr + STEP;
                    if (load_last) begin
                        state_nxt = RUN;
                        pc_nxt    = RESET_PC;
                    end
                end
            end

            RUN: begin
                instr       = imem_rdata;
                instr_valid = 1'b1;
                if (stall) begin
                    pc_nxt = pc;
                end else if (imem_rdata == HALT_INSTR) begin
                    state_nxt = HALT;
                end else if (branch_taken) begin
                    pc_nxt = branch_target & ALIGN_MASK;
                end else begin
                    pc_nxt = pc + STEP;
                end
            end

            HALT: begin
                halted = 1'b1;
                if (restart) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_PC;
                end else if (load_valid) begin
                    // word is not taken here; the loader holds it into LOAD
                    state_nxt    = LOAD;
                    load_ptr_nxt = RESET_PC;
                end
            end

            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl with a behavioural 64 KiB instruction memory.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic [15:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        restart;
    logic [15:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we) mem[imem_addr[15:2]] <= imem_wdata;
    assign imem_rdata = mem[imem_addr[15:2]];

    imem_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .imem_addr     (imem_addr),
        .imem_we       (imem_we),
        .imem_wdata    (imem_wdata),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .restart       (restart),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rst;
        logic [15:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Checks RUN/HALT outputs at mid-cycle, then advances one edge and drops one-shot CPU inputs.
    task automatic cyc(input string tag, input logic [15:0] epc, input logic evld,
                       input logic [31:0] ein, input logic ehalt);
        @(negedge clk);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".addr"}, imem_addr, epc);
        chk({tag, ".vld"}, instr_valid, evld);
        chk({tag, ".instr"}, instr, ein);
        chk({tag, ".halted"}, halted, ehalt);
        chk({tag, ".we"}, imem_we, 1'b0);
        chk({tag, ".rdy"}, load_ready, 1'b0);
        @(posedge clk); #1;
        stall = 1'b0; branch_taken = 1'b0; restart = 1'b0; branch_target = '0;
    endtask

    task automatic load_word(input string tag, input logic [31:0] d, input logic last,
                             input logic [15:0] eaddr);
        load_valid = 1'b1; load_data = d; load_last = last;
        @(negedge clk);
        chk({tag, ".rdy"}, load_ready, 1'b1);
        chk({tag, ".we"}, imem_we, 1'b1);
        chk({tag, ".addr"}, imem_addr, eaddr);
        chk({tag, ".wdata"}, imem_wdata, d);
        chk({tag, ".vld"}, instr_valid, 1'b0);
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        load_valid = 1'b0; load_last = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rdy"}, load_ready, 1'b1);
        chk({tag, ".we"}, imem_we, 1'b0);
        chk({tag, ".vld"}, instr_valid, 1'b0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".halted"}, halted, 1'b0);
        chk({tag, ".addr"}, imem_addr, 16'h0000);
        chk({tag, ".pc"}, pc, 16'h0000);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        //          stall br  tgt       rst  exp_pc    exp_instr
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 32'h1111_1111};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 32'h2222_2222};
        vecs[2]  = '{1'b1, 1'b1, 16'h0013, 1'b0, 16'h0008, 32'h3333_3333};
        vecs[3]  = '{1'b0, 1'b1, 16'h0013, 1'b0, 16'h0008, 32'h3333_3333};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0014, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFC, 32'h0000_0000};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 32'h1111_1111};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 32'h2222_2222};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 32'h2222_2222};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 32'h3333_3333};

        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0; restart = 1'b0;

        #3;
        chk("rst.rdy", load_ready, 1'b1);
        chk("rst.we", imem_we, 1'b0);
        chk("rst.vld", instr_valid, 1'b0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.addr", imem_addr, 16'h0000);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        load_word("ld3.w0", 32'h1111_1111, 1'b0, 16'h0000);
        load_word("ld3.w1", 32'h2222_2222, 1'b0, 16'h0004);
        load_word("ld3.w2", 32'h3333_3333, 1'b1, 16'h0008);

        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br;
            branch_target = vecs[i].tgt; restart = vecs[i].rst;
            cyc($sformatf("vec%0d", i), vecs[i].exp_pc, 1'b1, vecs[i].exp_instr, 1'b0);
        end

        reset_pulse("rst_run");
        load_word("part.w0", 32'hB000_0000, 1'b0, 16'h0000);
        load_word("part.w1", 32'hB000_0001, 1'b0, 16'h0004);
        reset_pulse("rst_load");
        load_word("re.w0", 32'hA000_0000, 1'b0, 16'h0000);
        load_word("re.w1", 32'hA000_0001, 1'b0, 16'h0004);
        load_word("re.w2", 32'hA000_0002, 1'b0, 16'h0008);
        load_word("re.w3", 32'hFFFF_FFFF, 1'b1, 16'h000C);

        cyc("h1.a", 16'h0000, 1'b1, 32'hA000_0000, 1'b0);
        cyc("h1.b", 16'h0004, 1'b1, 32'hA000_0001, 1'b0);
        cyc("h1.c", 16'h0008, 1'b1, 32'hA000_0002, 1'b0);
        branch_taken = 1'b1; branch_target = 16'h0040;
        cyc("h1.op", 16'h000C, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cyc("h1.halt", 16'h000C, 1'b0, 32'h0, 1'b1);
        restart = 1'b1;
        cyc("h1.rs", 16'h000C, 1'b0, 32'h0, 1'b1);
        cyc("h2.a", 16'h0000, 1'b1, 32'hA000_0000, 1'b0);
        cyc("h2.b", 16'h0004, 1'b1, 32'hA000_0001, 1'b0);
        cyc("h2.c", 16'h0008, 1'b1, 32'hA000_0002, 1'b0);
        cyc("h2.op", 16'h000C, 1'b1, 32'hFFFF_FFFF, 1'b0);
        restart = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_0000;
        cyc("h2.both", 16'h000C, 1'b0, 32'h0, 1'b1);
        load_valid = 1'b0;
        cyc("h3.a", 16'h0000, 1'b1, 32'hA000_0000, 1'b0);
        cyc("h3.b", 16'h0004, 1'b1, 32'hA000_0001, 1'b0);
        cyc("h3.c", 16'h0008, 1'b1, 32'hA000_0002, 1'b0);
        cyc("h3.op", 16'h000C, 1'b1, 32'hFFFF_FFFF, 1'b0);
        load_valid = 1'b1; load_data = 32'hD000_0000; load_last = 1'b1;
        cyc("h3.lv", 16'h000C, 1'b0, 32'h0, 1'b1);
        load_word("h3.ld", 32'hD000_0000, 1'b1, 16'h0000);
        cyc("h4.a", 16'h0000, 1'b1, 32'hD000_0000, 1'b0);
        cyc("h4.b", 16'h0004, 1'b1, 32'hA000_0001, 1'b0);
        cyc("h4.c", 16'h0008, 1'b1, 32'hA000_0002, 1'b0);
        cyc("h4.op", 16'h000C, 1'b1, 32'hFFFF_FFFF, 1'b0);
        load_valid = 1'b1; load_data = 32'h5000_0000; load_last = 1'b0;
        cyc("h4.lv", 16'h000C, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i <= 16384; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5000_0000 + 32'(i);
            load_last  = (i == 16384);
            @(negedge clk);
            if (i == 0 || i >= 16383) begin
                chk($sformatf("big%0d.we", i), imem_we, 1'b1);
                chk($sformatf("big%0d.addr", i), imem_addr,
                    (i == 16383) ? 16'hFFFC : 16'h0000);
            end
            @(posedge clk); #1;
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("big.mem0", mem[0], 32'h5000_4000);
        chk("big.memtop", mem[16383], 32'h5000_3FFF);
        cyc("big.run", 16'h0000, 1'b1, 32'h5000_4000, 1'b0);
        cyc("big.run2", 16'h0004, 1'b1, 32'h5000_0001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
